// File: rtl/axil_read_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between a read master and a slave.
interface axil_read_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_read_seq.sv
// Strided multi-beat AXI4-Lite read master with bounded outstanding reads,
// a one-entry output register and a done pulse carrying sticky error status.
module axil_read_seq #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_SHIFT      = 2,
    parameter int unsigned COUNT_WIDTH     = 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [ADDR_WIDTH-1:0]  start_base,
    input  logic [COUNT_WIDTH-1:0] start_count,
    input  logic [COUNT_WIDTH-1:0] start_stride,

    axil_read_if.master            s_axil,

    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,

    output logic                   done,
    output logic                   done_err
);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PROD_W = 2 * COUNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ADDR_WIDTH-1:0]  base_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] stride_q;
    logic [COUNT_WIDTH-1:0] issued;
    logic [COUNT_WIDTH-1:0] received;
    logic [OUT_W-1:0]       outstanding;
    logic                   err;
    logic                   err_nxt;
    logic                   arvalid_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;

    logic                   start_hs;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   last_r;
    logic                   rready_c;
    logic                   ar_want;
    logic [PROD_W-1:0]      offset;
    logic [ADDR_WIDTH-1:0]  word_addr;

    assign start_ready = (state == ST_IDLE);
    assign start_hs    = start_ready && start_valid;
    assign ar_hs       = arvalid_q && s_axil.arready;
    assign rready_c    = (state == ST_RUN) && (outstanding != '0) && (!out_valid || out_ready);
    assign r_hs        = rready_c && s_axil.rvalid;
    assign last_r      = (received == count_q - COUNT_WIDTH'(1));

    // A new AR is only raised from the idle-valid state, giving at most one AR per two cycles
    assign ar_want   = (state == ST_RUN) && !arvalid_q && (issued < count_q)
                       && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign offset    = PROD_W'(issued) * PROD_W'(stride_q);
    assign word_addr = base_q + ADDR_WIDTH'(offset);

    assign s_axil.araddr  = araddr_q;
    assign s_axil.arprot  = 3'b000;
    assign s_axil.arvalid = arvalid_q;
    assign s_axil.rready  = rready_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_valid) state_nxt = (start_count == '0) ? ST_FIN : ST_RUN;
            ST_RUN:  if (r_hs && last_r) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sticky error: cleared by a new command, set by any non-OKAY response
    always_comb begin
        err_nxt = err;
        if (start_hs)                                 err_nxt = 1'b0;
        else if (r_hs && (s_axil.rresp != 2'b00))     err_nxt = 1'b1;
    end

    // Command capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            count_q  <= '0;
            stride_q <= '0;
        end else if (start_hs) begin
            base_q   <= start_base;
            count_q  <= start_count;
            stride_q <= start_stride;
        end
    end

    // AR channel: address and valid held until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            issued    <= '0;
        end else if (start_hs) begin
            issued    <= '0;
        end else if (ar_hs) begin
            arvalid_q <= 1'b0;
            issued    <= issued + COUNT_WIDTH'(1);
        end else if (ar_want) begin
            arvalid_q <= 1'b1;
            araddr_q  <= word_addr << ADDR_SHIFT;
        end
    end

    // Reads in flight: accepted ARs not yet answered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, r_hs})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // R channel capture into the output register, beat counting and error tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            received  <= '0;
            err       <= 1'b0;
        end else begin
            if (r_hs) begin
                out_data  <= s_axil.rdata;
                out_valid <= 1'b1;
                out_last  <= last_r;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (start_hs)  received <= '0;
            else if (r_hs) received <= received + COUNT_WIDTH'(1);
            err <= err_nxt;
        end
    end

    // Completion pulse, asserted for the single cycle spent in FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            done     <= (state_nxt == ST_FIN);
            done_err <= (state_nxt == ST_FIN) && err_nxt;
        end
    end
endmodule

// File: tb/tb_axil_read_seq.sv
// Randomized bench for axil_read_seq: behavioural AXI-Lite slave, consumer and
// a command-level reference model of addresses, beats and error status.
`timescale 1ns/1ps
module tb_axil_read_seq;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned SH   = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned MAXO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] start_base;
    logic [CW-1:0] start_count;
    logic [CW-1:0] start_stride;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          done;
    logic          done_err;

    axil_read_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    axil_read_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_SHIFT(SH),
        .COUNT_WIDTH(CW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_base(start_base), .start_count(start_count), .start_stride(start_stride),
        .s_axil(axil),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .done_err(done_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rreq_t;

    rreq_t         rq[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW:0]   exp_beat_q[$];
    bit            bad_addr[int];
    logic [DW-1:0] mem_ov[int];

    int n_checks = 0;
    int n_fail   = 0;
    int ar_pct = 100, or_pct = 100, dly_min = 0, dly_max = 0;
    int oready_hold = 0, arready_hold = 0;
    int cyc = 0, outst = 0, ar_cnt = 0, r_cnt = 0;
    int cmd_ar0 = 0, cmd_r0 = 0;
    bit r_pop = 0;
    bit stall_prev = 0;
    logic [AW-1:0] stall_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (mem_ov.exists(int'(a))) return mem_ov[int'(a)];
        return {a ^ 16'hC3A5, a + 16'h1357};
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] b, input int i, input int s);
        int a;
        a = (int'(b) + i * s) << SH;
        return a[AW-1:0];
    endfunction

    // AXI-Lite slave and output consumer; drives at negedge, observes 1ns later
    initial begin
        rreq_t  head;
        logic [DW:0] beat;
        axil.arready = 1'b0;
        axil.rvalid  = 1'b0;
        axil.rdata   = '0;
        axil.rresp   = 2'b00;
        out_ready    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rq.delete();
                exp_addr_q.delete();
                exp_beat_q.delete();
                axil.arready = 1'b0;
                axil.rvalid  = 1'b0;
                outst = 0;
                r_pop = 0;
                stall_prev = 0;
                continue;
            end
            if (r_pop) begin
                axil.rvalid = 1'b0;
                r_pop = 0;
            end
            if (!axil.rvalid && rq.size() > 0 && rq[0].due <= cyc) begin
                head = rq.pop_front();
                axil.rvalid = 1'b1;
                axil.rdata  = mem_word(head.addr);
                axil.rresp  = bad_addr.exists(int'(head.addr)) ? 2'd2 : 2'd0;
            end
            if (arready_hold > 0) begin
                axil.arready = 1'b0;
                arready_hold--;
            end else begin
                axil.arready = ($urandom_range(0, 99) < ar_pct);
            end
            if (oready_hold > 0) begin
                out_ready = 1'b0;
                oready_hold--;
            end else begin
                out_ready = ($urandom_range(0, 99) < or_pct);
            end
            #1;
            if (stall_prev) begin
                chk("ar_hold_valid", axil.arvalid, 1);
                chk("ar_hold_addr", axil.araddr, stall_addr);
            end
            stall_prev = axil.arvalid && !axil.arready;
            stall_addr = axil.araddr;
            if (outst >= MAXO) chk("arvalid_at_limit", axil.arvalid, 0);
            if (out_valid && !out_ready) chk("rready_backpressure", axil.rready, 0);
            if (axil.arvalid && axil.arready) begin
                chk("outstanding_limit", outst < MAXO, 1);
                chk("arprot", axil.arprot, 0);
                if (exp_addr_q.size() == 0) chk("ar_unexpected", exp_addr_q.size(), 1);
                else                        chk("araddr", axil.araddr, exp_addr_q.pop_front());
                rq.push_back('{axil.araddr, cyc + $urandom_range(dly_min, dly_max)});
                outst++;
                ar_cnt++;
            end
            if (axil.rvalid && axil.rready) begin
                r_pop = 1;
                outst--;
                r_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_beat_q.size() == 0) begin
                    chk("beat_unexpected", exp_beat_q.size(), 1);
                end else begin
                    beat = exp_beat_q.pop_front();
                    chk("out_data", out_data, beat[DW-1:0]);
                    chk("out_last", out_last, beat[DW]);
                end
            end
        end
    end

    // Reference model of one command plus the start handshake
    bit cur_err;
    task automatic start_cmd(input logic [AW-1:0] b, input int c, input int s);
        logic [AW-1:0] a;
        bit ok;
        cur_err = 0;
        for (int i = 0; i < c; i++) begin
            a = beat_addr(b, i, s);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({(i == c - 1), mem_word(a)});
            if (bad_addr.exists(int'(a))) cur_err = 1;
        end
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #2;
            if (start_ready) begin ok = 1; break; end
        end
        chk("start_ready", ok, 1);
        cmd_ar0 = ar_cnt;
        cmd_r0  = r_cnt;
        start_base   = b;
        start_count  = CW'(c);
        start_stride = CW'(s);
        start_valid  = 1'b1;
        @(posedge clk); #1;
        start_valid  = 1'b0;
    endtask

    task automatic wait_done(input int c, input bit e, output int lat);
        bit seen;
        seen = 0;
        lat  = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #2;
            if (done) begin seen = 1; lat = k; break; end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("done_err", done_err, e);
            chk("ar_count", ar_cnt - cmd_ar0, c);
            chk("r_count", r_cnt - cmd_r0, c);
            chk("arvalid_at_done", axil.arvalid, 0);
            @(negedge clk); #2;
            chk("done_pulse_width", done, 0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #2;
            if (exp_beat_q.size() == 0 && !out_valid) break;
        end
        chk("beats_drained", exp_beat_q.size(), 0);
        chk("addrs_drained", exp_addr_q.size(), 0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input int c, input int s, input bit do_drain);
        int lat;
        start_cmd(b, c, s);
        wait_done(c, cur_err, lat);
        if (do_drain) drain();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_arvalid"}, axil.arvalid, 0);
        chk({tag, "_araddr"}, axil.araddr, 0);
        chk({tag, "_rready"}, axil.rready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_err"}, done_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c, s, j;
        logic [AW-1:0] b;
        rst = 1'b1;
        start_valid = 1'b0;
        start_base = '0;
        start_count = '0;
        start_stride = '0;
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk); #2;
        check_reset_values("reset");

        // Single beat
        ar_pct = 100; or_pct = 100; dly_min = 2; dly_max = 2;
        mem_ov[16'h0014] = 32'hDEADBEEF;
        run_cmd(16'd5, 1, 1, 1);

        // Strided burst
        dly_min = 0; dly_max = 3;
        run_cmd(16'h0010, 4, 3, 1);

        // Outstanding limit with slow slave
        dly_min = 10; dly_max = 10;
        run_cmd(16'h0040, 5, 1, 1);

        // Output backpressure and AR stall mid-burst
        dly_min = 1; dly_max = 1;
        start_cmd(16'h0200, 8, 2);
        repeat (5) @(negedge clk);
        oready_hold = 6;
        arready_hold = 3;
        wait_done(8, cur_err, lat);
        drain();

        // Error on the second beat, then zero count
        dly_min = 0; dly_max = 2;
        bad_addr.delete();
        bad_addr[int'(beat_addr(16'h0030, 1, 1))] = 1;
        run_cmd(16'h0030, 3, 1, 1);
        bad_addr.delete();
        start_cmd(16'h0077, 0, 5);
        wait_done(0, cur_err, lat);
        chk("zero_count_done_latency", lat, 0);

        // Randomized commands, including address wrap, stride 0 and overlap with pending beats
        for (int n = 0; n < 25; n++) begin
            b = AW'($urandom);
            c = $urandom_range(0, 12);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
            ar_pct = $urandom_range(30, 100);
            or_pct = $urandom_range(30, 100);
            dly_min = 0;
            dly_max = $urandom_range(0, 8);
            bad_addr.delete();
            if (c > 0 && $urandom_range(0, 2) == 0) begin
                j = $urandom_range(0, c - 1);
                bad_addr[int'(beat_addr(b, j, s))] = 1;
            end
            run_cmd(b, c, s, ($urandom_range(0, 1) == 1));
        end
        drain();
        bad_addr.delete();

        // Asynchronous reset in the middle of a burst
        ar_pct = 100; or_pct = 100; dly_min = 3; dly_max = 3;
        start_cmd(16'h0100, 8, 1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_arvalid", axil.arvalid, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_rready", axil.rready, 0);
        chk("async_rst_start_ready", start_ready, 1);
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk); #2;
        check_reset_values("post_rst");
        run_cmd(16'h0123, 2, 7, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
